// File: rtl/fwd_scoreboard_unit.sv
// Operand scoreboard between OF and EX. It tracks in-flight destinations over DEPTH
// stages and resolves forwarding, the regfile bypass and the load-use stall for each source.
module fwd_scoreboard_unit #(
    parameter int REG_W            = 4,
    parameter int NUM_SRC          = 2,
    parameter int DEPTH            = 3,
    parameter int LOAD_READY       = 2,
    parameter int RF_WRITE_THROUGH = 0,
    parameter int CNT_W            = 32,
    localparam int SEL_W           = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       hold,
    input  logic                       flush,
    input  logic                       cnt_clear,
    input  logic                       of_valid,
    input  logic [NUM_SRC*REG_W-1:0]   of_src_addr,
    input  logic [NUM_SRC-1:0]         of_src_used,
    input  logic [REG_W-1:0]           of_dest_addr,
    input  logic                       of_dest_wr,
    input  logic                       of_is_load,
    output logic                       stall,
    output logic [NUM_SRC-1:0]         of_fwd_rw,
    output logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel,
    output logic                       ex_valid,
    output logic [CNT_W-1:0]           stall_count
);

    logic [DEPTH:1]             v_q, v_d, wr_q, wr_d, ld_q, ld_d;
    logic [REG_W-1:0]           dest_q [DEPTH:1];
    logic [REG_W-1:0]           dest_d [DEPTH:1];
    logic [NUM_SRC*SEL_W-1:0]   sel_q, sel_d;
    logic                       ex_valid_q, ex_valid_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    logic [NUM_SRC-1:0]         hit_s, near_ld_s, stall_vec_s, rw_s;
    logic [SEL_W-1:0]           near_k_s [NUM_SRC];
    logic [NUM_SRC*SEL_W-1:0]   sel_new_s;
    logic                       stall_s, take_s;

    // Nearest-producer search: scanning far to near lets the nearest match overwrite the rest.
    always_comb begin
        hit_s       = '0;
        near_ld_s   = '0;
        stall_vec_s = '0;
        rw_s        = '0;
        sel_new_s   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            near_k_s[i] = '0;
            for (int k = DEPTH; k >= 1; k--) begin
                logic match;
                match = of_valid & of_src_used[i] & v_q[k] & wr_q[k]
                        & (dest_q[k] == of_src_addr[i*REG_W +: REG_W]);
                hit_s[i]     = hit_s[i] | match;
                near_k_s[i]  = match ? SEL_W'(k) : near_k_s[i];
                near_ld_s[i] = match ? ld_q[k] : near_ld_s[i];
            end
            stall_vec_s[i] = hit_s[i] & near_ld_s[i] & (int'(near_k_s[i]) < LOAD_READY);
            rw_s[i] = ~flush & hit_s[i] & (int'(near_k_s[i]) == DEPTH) & (RF_WRITE_THROUGH == 0);
            // A producer at k moves to k+1 by the time the consumer reaches EX.
            sel_new_s[i*SEL_W +: SEL_W] = (hit_s[i] && (int'(near_k_s[i]) < DEPTH))
                                          ? near_k_s[i] + SEL_W'(1) : SEL_W'(0);
        end
        stall_s = ~flush & (|stall_vec_s);
        take_s  = of_valid & ~flush & ~stall_s;
    end

    // Next-state: shift the records, load record 1 and update the stall counter.
    always_comb begin
        v_d        = v_q;
        wr_d       = wr_q;
        ld_d       = ld_q;
        dest_d     = dest_q;
        sel_d      = sel_q;
        ex_valid_d = ex_valid_q;
        if (!hold) begin
            for (int k = DEPTH; k >= 2; k--) begin
                v_d[k]    = v_q[k-1];
                wr_d[k]   = wr_q[k-1];
                ld_d[k]   = ld_q[k-1];
                dest_d[k] = dest_q[k-1];
            end
            v_d[1]     = take_s;
            wr_d[1]    = of_dest_wr;
            ld_d[1]    = of_is_load;
            dest_d[1]  = of_dest_addr;
            ex_valid_d = take_s;
            sel_d      = take_s ? sel_new_s : '0;
        end else begin
            ex_valid_d = ex_valid_q;
        end
        if (cnt_clear) begin
            cnt_d = '0;
        end else if (stall_s && !hold && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q        <= '0;
            wr_q       <= '0;
            ld_q       <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                dest_q[k] <= '0;
            end
            sel_q      <= '0;
            ex_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            v_q        <= v_d;
            wr_q       <= wr_d;
            ld_q       <= ld_d;
            dest_q     <= dest_d;
            sel_q      <= sel_d;
            ex_valid_q <= ex_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign stall       = stall_s;
    assign of_fwd_rw   = rw_s;
    assign ex_fwd_sel  = sel_q;
    assign ex_valid    = ex_valid_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Directed bench: dut0 uses a 4-bit counter, dut1 uses regfile write-through and a 32-bit counter.
module tb_fwd_scoreboard_unit;

    logic        clk = 1'b0;
    logic        reset, hold, flush, cnt_clear, of_valid, of_dest_wr, of_is_load;
    logic [7:0]  of_src_addr;
    logic [1:0]  of_src_used;
    logic [3:0]  of_dest_addr;

    logic        stall0, stall1, ev0, ev1;
    logic [1:0]  rw0, rw1;
    logic [3:0]  sel0, sel1;
    logic [3:0]  cnt0;
    logic [31:0] cnt1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fwd_scoreboard_unit #(.CNT_W(4)) dut0 (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .cnt_clear(cnt_clear),
        .of_valid(of_valid), .of_src_addr(of_src_addr), .of_src_used(of_src_used),
        .of_dest_addr(of_dest_addr), .of_dest_wr(of_dest_wr), .of_is_load(of_is_load),
        .stall(stall0), .of_fwd_rw(rw0), .ex_fwd_sel(sel0), .ex_valid(ev0), .stall_count(cnt0)
    );

    fwd_scoreboard_unit #(.RF_WRITE_THROUGH(1)) dut1 (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .cnt_clear(cnt_clear),
        .of_valid(of_valid), .of_src_addr(of_src_addr), .of_src_used(of_src_used),
        .of_dest_addr(of_dest_addr), .of_dest_wr(of_dest_wr), .of_is_load(of_is_load),
        .stall(stall1), .of_fwd_rw(rw1), .ex_fwd_sel(sel1), .ex_valid(ev1), .stall_count(cnt1)
    );

    typedef struct {
        logic       vld;
        logic [3:0] s0, s1;
        logic [1:0] used;
        logic [3:0] dest;
        logic       wr, ld, hld;
        logic       e_stall;
        logic [1:0] e_rw;
        logic       e_ev;
        logic [1:0] e_sel0, e_sel1;
        int         e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic vld, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [1:0] used, input logic [3:0] dest, input logic wr,
                       input logic ld, input logic hld, input logic e_stall,
                       input logic [1:0] e_rw, input logic e_ev, input logic [1:0] e_sel0,
                       input logic [1:0] e_sel1, input int e_cnt);
        vec_t v;
        v = '{vld, s0, s1, used, dest, wr, ld, hld, e_stall, e_rw, e_ev, e_sel0, e_sel1, e_cnt};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [3:0] s0, input logic [3:0] s1,
                         input logic [1:0] used, input logic [3:0] dest, input logic wr,
                         input logic ld);
        of_valid     = vld;
        of_src_addr  = {s1, s0};
        of_src_used  = used;
        of_dest_addr = dest;
        of_dest_wr   = wr;
        of_is_load   = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stall_seen;
        reset = 1'b1; hold = 1'b0; flush = 1'b0; cnt_clear = 1'b0;
        drive(1'b1, 4'd3, 4'd3, 2'b11, 4'd3, 1'b1, 1'b1);

        //   vld s0 s1 used dest wr ld hold | stall rw | ev sel0 sel1 cnt
        add(1, 1, 2, 2'b11, 3, 1, 0, 0,  0, 2'b00,  1, 0, 0, 0);  // add r3
        add(1, 3, 5, 2'b11, 4, 1, 0, 0,  0, 2'b00,  1, 2, 0, 0);  // sub r4,r3,r5
        add(1, 1, 0, 2'b01, 2, 1, 1, 0,  0, 2'b00,  1, 0, 0, 0);  // ld r2
        add(1, 2, 1, 2'b11, 6, 1, 0, 0,  1, 2'b00,  0, 0, 0, 1);  // add r6,r2,r1 stalls
        add(1, 2, 1, 2'b11, 6, 1, 0, 0,  0, 2'b00,  1, 3, 0, 1);  // retried, load now in MA
        add(1, 2, 0, 2'b01, 10, 1, 0, 0, 0, 2'b01,  1, 0, 0, 1);  // r2 in RW: bypass
        add(1, 0, 0, 2'b00, 7, 1, 1, 0,  0, 2'b00,  1, 0, 0, 1);  // ld r7
        add(1, 6, 0, 2'b01, 7, 1, 0, 0,  0, 2'b01,  1, 0, 0, 1);  // mov r7,r6
        add(1, 7, 7, 2'b11, 8, 1, 0, 0,  0, 2'b00,  1, 2, 2, 1);  // add r8,r7,r7 shadowed
        add(1, 1, 0, 2'b01, 5, 0, 0, 1,  0, 2'b00,  1, 2, 2, 1);  // hold keeps selects
        add(1, 1, 0, 2'b01, 5, 0, 0, 0,  0, 2'b00,  1, 0, 0, 1);  // store, wr=0
        add(1, 5, 8, 2'b11, 9, 1, 0, 0,  0, 2'b00,  1, 0, 3, 1);  // wr=0 never matches
        add(1, 9, 8, 2'b10, 0, 0, 0, 0,  0, 2'b10,  1, 0, 0, 1);  // unused src0
        add(0, 9, 9, 2'b11, 0, 0, 0, 0,  0, 2'b00,  0, 0, 0, 1);  // invalid OF
        add(1, 0, 0, 2'b00, 13, 1, 1, 0, 0, 2'b00,  1, 0, 0, 1);  // ld r13
        add(1, 13, 0, 2'b01, 14, 1, 0, 1, 1, 2'b00, 1, 0, 0, 1);  // hold during stall
        add(1, 13, 0, 2'b01, 14, 1, 0, 1, 1, 2'b00, 1, 0, 0, 1);
        add(1, 13, 0, 2'b01, 14, 1, 0, 1, 1, 2'b00, 1, 0, 0, 1);
        add(1, 13, 0, 2'b01, 14, 1, 0, 0, 1, 2'b00, 0, 0, 0, 2);
        add(1, 13, 0, 2'b01, 14, 1, 0, 0, 0, 2'b00, 1, 3, 0, 2);

        #12;
        check("reset ex_valid", {30'd0, ev1, ev0}, 32'd0);
        check("reset sel", {24'd0, sel1, sel0}, 32'd0);
        check("reset cnt0", {28'd0, cnt0}, 32'd0);
        check("reset cnt1", cnt1, 32'd0);
        check("reset stall", {30'd0, stall1, stall0}, 32'd0);
        check("reset rw", {28'd0, rw1, rw0}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk);
            drive(vecs[r].vld, vecs[r].s0, vecs[r].s1, vecs[r].used, vecs[r].dest,
                  vecs[r].wr, vecs[r].ld);
            hold = vecs[r].hld;
            #2;
            check($sformatf("row%0d stall0", r), {31'd0, stall0}, {31'd0, vecs[r].e_stall});
            check($sformatf("row%0d stall1", r), {31'd0, stall1}, {31'd0, vecs[r].e_stall});
            check($sformatf("row%0d rw0", r), {30'd0, rw0}, {30'd0, vecs[r].e_rw});
            check($sformatf("row%0d rw1", r), {30'd0, rw1}, 32'd0);
            tick();
            check($sformatf("row%0d ex_valid", r), {30'd0, ev1, ev0},
                  {30'd0, vecs[r].e_ev, vecs[r].e_ev});
            check($sformatf("row%0d sel0", r), {28'd0, sel0},
                  {28'd0, vecs[r].e_sel1, vecs[r].e_sel0});
            check($sformatf("row%0d sel1", r), {28'd0, sel1},
                  {28'd0, vecs[r].e_sel1, vecs[r].e_sel0});
            check($sformatf("row%0d cnt0", r), {28'd0, cnt0}, vecs[r].e_cnt);
            check($sformatf("row%0d cnt1", r), cnt1, vecs[r].e_cnt);
        end
        hold = 1'b0;

        // Flush wins over a pending load-use stall.
        @(negedge clk);
        drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd11, 1'b1, 1'b1);
        tick();
        @(negedge clk);
        drive(1'b1, 4'd11, 4'd0, 2'b01, 4'd12, 1'b1, 1'b0);
        #1;
        check("preflush stall", {31'd0, stall0}, 32'd1);
        flush = 1'b1;
        #1;
        check("flush stall", {31'd0, stall0}, 32'd0);
        tick();
        check("flush ex_valid", {31'd0, ev0}, 32'd0);
        check("flush cnt0", {28'd0, cnt0}, 32'd2);
        @(negedge clk);
        flush = 1'b0;

        // 20 load-use stalls: 4-bit counter saturates, 32-bit one does not.
        stall_seen = 0;
        for (int n = 0; n < 20; n++) begin
            drive(1'b1, 4'd2, 4'd0, 2'b01, 4'd2, 1'b1, 1'b1);
            tick();
            @(negedge clk);
            drive(1'b1, 4'd2, 4'd0, 2'b01, 4'd6, 1'b1, 1'b0);
            #1;
            if (stall0 === 1'b1) stall_seen++;
            tick();
            @(negedge clk);
        end
        check("stall cycles", stall_seen, 32'd20);
        check("sat cnt0", {28'd0, cnt0}, 32'd15);
        check("sat cnt1", cnt1, 32'd22);

        // cnt_clear beats a simultaneous stall increment.
        drive(1'b1, 4'd2, 4'd0, 2'b01, 4'd2, 1'b1, 1'b1);
        tick();
        @(negedge clk);
        drive(1'b1, 4'd2, 4'd0, 2'b01, 4'd6, 1'b1, 1'b0);
        cnt_clear = 1'b1;
        tick();
        check("clear cnt0", {28'd0, cnt0}, 32'd0);
        check("clear cnt1", cnt1, 32'd0);
        @(negedge clk);
        cnt_clear = 1'b0;
        drive(1'b1, 4'd2, 4'd0, 2'b01, 4'd2, 1'b1, 1'b1);
        tick();
        @(negedge clk);
        drive(1'b1, 4'd2, 4'd0, 2'b01, 4'd6, 1'b1, 1'b0);
        tick();
        check("post clear cnt0", {28'd0, cnt0}, 32'd1);

        // Reset in the middle of a stall acts without a clock edge.
        @(negedge clk);
        drive(1'b1, 4'd2, 4'd0, 2'b01, 4'd2, 1'b1, 1'b1);
        tick();
        @(negedge clk);
        drive(1'b1, 4'd2, 4'd0, 2'b01, 4'd6, 1'b1, 1'b0);
        #1;
        check("prereset stall", {31'd0, stall0}, 32'd1);
        reset = 1'b1;
        #1;
        check("async reset stall", {31'd0, stall0}, 32'd0);
        check("async reset cnt0", {28'd0, cnt0}, 32'd0);
        check("async reset cnt1", cnt1, 32'd0);
        check("async reset ex_valid", {31'd0, ev0}, 32'd0);
        #1;
        reset = 1'b0;
        tick();
        check("post reset ex_valid", {31'd0, ev0}, 32'd1);
        check("post reset sel", {28'd0, sel0}, 32'd0);
        check("post reset cnt0", {28'd0, cnt0}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard_unit.md
Name: fwd_scoreboard_unit

Overview:
Parametrised successor to the combinational src1 forwarding detector. It tracks in-flight destination registers across a configurable number of post-OF stages and resolves every source operand of the OF-stage instruction in one place, for NUM_SRC operands. Outputs are:
- registered EX-stage forwarding selects
- an OF-stage regfile-bypass flag
- the load-use interlock stall
- a stall-cycle performance counter

It sits between decode (OF) and the EX operand muxes.

Parameters:
REG_W, 4, register address width (16 architectural registers; ra = 15 is resolved by decode before entry)
NUM_SRC, 2, number of source operands checked per instruction
DEPTH, 3, tracked stages after OF (1=EX, 2=MA, ..., DEPTH=RW); legal range 2..7
LOAD_READY, 2, lowest stage index at which a load result is forwardable from that stage onward
RF_WRITE_THROUGH, 0, 1 = regfile returns the same-cycle write, so of_fwd_rw is forced to 0
CNT_W, 32, width of stall_count

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
hold  in  1  global pipeline freeze (memory wait); no state advances
flush  in  1  branch taken in EX; the instruction in OF is killed
cnt_clear  in  1  synchronous clear of stall_count
of_valid  in  1  OF holds a real instruction
of_src_addr  in  NUM_SRC*REG_W  source register addresses; operand i is at [i*REG_W +: REG_W]
of_src_used  in  NUM_SRC  operand i is actually read
of_dest_addr  in  REG_W  destination register (ra already substituted for call)
of_dest_wr  in  1  instruction writes of_dest_addr
of_is_load  in  1  instruction is a load
stall  out  1  load-use interlock: keep IF/OF, insert bubble into EX
of_fwd_rw  out  NUM_SRC  operand i must take the RW-stage result instead of the regfile read
ex_fwd_sel  out  NUM_SRC*SEL_W  SEL_W = clog2(DEPTH+1); 0 = regfile/OF value, k = forward from stage k
ex_valid  out  1  EX holds a tracked, valid instruction
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- State: per stage k (1..DEPTH), a record {v, wr, ld, dest}.
  - Producer at k means v & wr, with dest matching the source address.
- Reset (asynchronous): all v=0, ex_fwd_sel=0, ex_valid=0, stall_count=0. Consequently stall=0 and of_fwd_rw=0.
- Match search: for each operand i with of_valid & of_src_used[i], find the nearest producer, i.e. the smallest k with dest==src_i. Nearer producers shadow farther ones.
- Load-use stall:
  - Combinational: stall = ~flush & OR over i of (nearest producer k exists, its ld=1, and k+1 < LOAD_READY+1, i.e. k < LOAD_READY).
  - A load at stage 1 with the default parameters stalls exactly 1 cycle.
  - A far load that is shadowed by a nearer non-load producer never stalls.
- of_fwd_rw[i] (combinational): 1 iff the nearest producer is k=DEPTH and RF_WRITE_THROUGH=0. It is gated by ~flush.
- Advance, each clock with hold=0:
  - Records k=2..DEPTH take the contents of k-1.
  - Record 1 takes the OF instruction only if of_valid & ~flush & ~stall; otherwise it takes a bubble (v=0).
  - ex_valid equals the new record-1 v.
- ex_fwd_sel[i] is registered together with record 1:
  - Nearest producer at k < DEPTH gives k+1, which is where the producer sits when the consumer reaches EX.
  - Otherwise 0.
  - It is 0 for bubbles and for unused operands.
- hold=1: all records, ex_fwd_sel and ex_valid are frozen. stall and of_fwd_rw still evaluate combinationally on the frozen state. stall_count does not increment.
- flush and stall together: flush wins. stall=0, a bubble enters EX, and nothing is counted.
- stall_count:
  - Increments on clocks where stall=1 and hold=0.
  - Saturates at all-ones.
  - cnt_clear has priority over increment.
- Multiple operands matching different stages: each is resolved independently. Both operands matching the same producer give identical selects.
- A producer with wr=0 (store, branch, nop) never matches.
- Reset mid-stall: stall drops asynchronously with reset. The first post-reset instruction enters EX unhindered.
- Latency: stall and of_fwd_rw are 0-cycle (combinational); ex_fwd_sel and ex_valid are 1 cycle.

Test Plan:
- Back-to-back ALU, DEPTH=3: add r3 then sub r4,r3,r5 -> consumer in EX has ex_fwd_sel[0]=2 (MA); stall=0; stall_count unchanged.
- Load-use: ld r2 then add r6,r2,r1 -> stall=1 for exactly 1 cycle, bubble in EX (ex_valid=0), then ex_fwd_sel[0]=3 (RW); stall_count=1.
- Shadowing: ld r7, mov r7, add r8,r7,r7 -> nearest producer is mov, so stall=0 and ex_fwd_sel[0]=ex_fwd_sel[1]=2.
- RW bypass: producer of r9 in RW while consumer of r9 is in OF -> of_fwd_rw[0]=1. Same stimulus with RF_WRITE_THROUGH=1 -> 0.
- flush with a load-use pending: flush=1 in the stall cycle -> stall=0, bubble enters EX, stall_count unchanged. hold=1 for 3 cycles -> all outputs stable, records unshifted.
- Saturation and reset: CNT_W=4, force 20 stall cycles -> stall_count=15. Assert reset mid-stall -> stall=0 and stall_count=0 immediately, without waiting for a clock.
